// File: rtl/tt_pkg.sv
// Shared definitions for the truth-table scanner: FSM encoding and parameter limits.
package tt_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } tt_state_e;

   localparam int unsigned NVARS_MIN  = 2;
   localparam int unsigned NVARS_MAX  = 6;
   localparam int unsigned SETTLE_MIN = 1;
   localparam int unsigned SETTLE_MAX = 15;

   // Settle counter must hold values up to SETTLE_MAX-1.
   localparam int unsigned SETTLE_W   = $clog2(SETTLE_MAX + 1);

   // Keep the settle time inside the supported range.
   function automatic int unsigned clamp_settle(input int unsigned s);
      if (s < SETTLE_MIN) return SETTLE_MIN;
      if (s > SETTLE_MAX) return SETTLE_MAX;
      return s;
   endfunction

endpackage

// File: rtl/tt_first_diff.sv
// Lowest-set-bit priority encoder: index of the first differing truth-table entry.
module tt_first_diff #(
   parameter int unsigned W  = 8,
   parameter int unsigned IW = 3
) (
   input  logic [W-1:0]  vec_i,
   output logic [IW-1:0] idx_o,
   output logic          found_o
);

   // Scan from the top down so the lowest set bit is the last one to win.
   always_comb begin
      idx_o   = '0;
      found_o = 1'b0;
      for (int i = int'(W) - 1; i >= 0; i--) begin
         if (vec_i[i]) begin
            idx_o   = IW'(i);
            found_o = 1'b1;
         end
      end
   end

endmodule

// File: rtl/truth_table_scan.sv
// Walks every input combination of an external Boolean function, records its
// truth table and compares it against a minterm or maxterm reference mask.
module truth_table_scan
   import tt_pkg::*;
#(
   parameter int unsigned NVARS  = 3,
   parameter int unsigned SETTLE = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  abort,
   input  logic                  mode,
   input  logic [(1<<NVARS)-1:0] ref_table,
   input  logic                  f_in,
   output logic [NVARS-1:0]      vars,
   output logic                  busy,
   output logic                  done,
   output logic [(1<<NVARS)-1:0] table_out,
   output logic [NVARS:0]        ones,
   output logic                  match,
   output logic [NVARS-1:0]      diff_idx
);

   localparam int unsigned TW       = 1 << NVARS;
   localparam int unsigned CW       = NVARS + 1;
   localparam int unsigned SETTLE_C = clamp_settle(SETTLE);

   tt_state_e             state_q, state_d;
   logic [NVARS-1:0]      vars_q, vars_d;
   logic [SETTLE_W-1:0]   cnt_q, cnt_d;
   logic [TW-1:0]         eff_ref_q, eff_ref_d;
   logic [TW-1:0]         table_q, table_d;
   logic [CW-1:0]         ones_q, ones_d;
   logic                  match_q, match_d;
   logic [NVARS-1:0]      diff_q, diff_d;
   logic                  busy_q, busy_d;
   logic                  done_q, done_d;

   logic [NVARS-1:0]      first_idx;
   logic                  any_diff;

   // Compare against the table as it will look after this cycle's sample.
   tt_first_diff #(
      .W  (TW),
      .IW (NVARS)
   ) u_first_diff (
      .vec_i   (table_d ^ eff_ref_q),
      .idx_o   (first_idx),
      .found_o (any_diff)
   );

   // State and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         vars_q    <= '0;
         cnt_q     <= '0;
         eff_ref_q <= '0;
         table_q   <= '0;
         ones_q    <= '0;
         match_q   <= 1'b0;
         diff_q    <= '0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         vars_q    <= vars_d;
         cnt_q     <= cnt_d;
         eff_ref_q <= eff_ref_d;
         table_q   <= table_d;
         ones_q    <= ones_d;
         match_q   <= match_d;
         diff_q    <= diff_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Next-state and datapath control.
   always_comb begin
      state_d   = state_q;
      vars_d    = vars_q;
      cnt_d     = cnt_q;
      eff_ref_d = eff_ref_q;
      table_d   = table_q;
      ones_d    = ones_q;
      match_d   = match_q;
      diff_d    = diff_q;
      done_d    = 1'b0;

      case (state_q)
         IDLE: begin
            if (start) begin
               eff_ref_d = mode ? ~ref_table : ref_table;
               table_d   = '0;
               ones_d    = '0;
               match_d   = 1'b0;
               diff_d    = '0;
               vars_d    = '0;
               cnt_d     = '0;
               state_d   = SCAN;
            end
         end
         SCAN: begin
            if (abort) begin
               state_d = IDLE;
            end else if (cnt_q == SETTLE_W'(SETTLE_C - 1)) begin
               table_d[vars_q] = f_in;
               ones_d          = ones_q + CW'(f_in);
               cnt_d           = '0;
               if (vars_q == {NVARS{1'b1}}) begin
                  match_d = ~any_diff;
                  diff_d  = first_idx;
                  state_d = DONE;
               end else begin
                  vars_d = vars_q + NVARS'(1);
               end
            end else begin
               cnt_d = cnt_q + SETTLE_W'(1);
            end
         end
         DONE: begin
            done_d  = 1'b1;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase

      busy_d = (state_d != IDLE);
   end

   assign vars      = vars_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign table_out = table_q;
   assign ones      = ones_q;
   assign match     = match_q;
   assign diff_idx  = diff_q;

endmodule

// File: doc/truth_table_scan.md
TRUTH_TABLE_SCAN -- requirements
Module: truth_table_scan

Interface
REQ-001 The module SHALL have parameter NVARS, default 3, giving the number of Boolean input variables; legal range 2..6.
REQ-002 The module SHALL have parameter SETTLE, default 1, giving the cycles each input combination is held before sampling; legal range 1..15.
REQ-003 The module SHALL have one clock and an asynchronous, active-low reset: clk input 1, rising-edge clock; rst_n input 1, active-low reset.
REQ-004 start  input  1  request a scan; accepted only in IDLE.
REQ-005 abort  input  1  synchronous cancel of a running scan.
REQ-006 mode  input  1  0: ref is a minterm mask; 1: ref is a maxterm mask; captured at start.
REQ-007 ref_table  input  2**NVARS  expected truth table; captured at start.
REQ-008 f_in  input  1  output of the external function under test.
REQ-009 vars  output  NVARS  combination driven to the function under test; vars[NVARS-1] is the most significant variable (x).
REQ-010 busy  output  1  scan in progress.
REQ-011 done  output  1  one-cycle completion pulse.
REQ-012 table_out  output  2**NVARS  captured truth table; bit i is f_in sampled at vars==i.
REQ-013 ones  output  NVARS+1  count of 1 bits in table_out.
REQ-014 match  output  1  table_out equals the effective reference.
REQ-015 diff_idx  output  NVARS  lowest index where table_out differs from the effective reference; 0 when match=1.

Function
REQ-016 The FSM SHALL have exactly three states: IDLE, SCAN and DONE.
REQ-017 In IDLE, a cycle with start=1 SHALL capture mode and ref_table, clear table_out, ones, match and diff_idx, load vars=0 and the settle counter to 0, and move to SCAN.
REQ-018 Effective reference SHALL be ref_table when mode=0 and ~ref_table when mode=1.
REQ-019 In SCAN, vars SHALL stay constant for SETTLE cycles.
REQ-020 At the clock edge ending the SETTLE-th cycle, the block SHALL write table_out[vars] <= f_in, add f_in to ones, and then increment vars.
REQ-021 When the sample at vars = 2**NVARS-1 is taken, the FSM SHALL go to DONE; vars SHALL hold its all-ones value and SHALL NOT wrap during the scan.
REQ-022 In DONE, match and diff_idx SHALL be valid and done=1 for exactly one cycle; the FSM SHALL then return to IDLE.
REQ-023 done SHALL rise exactly 1 + 2**NVARS*SETTLE cycles after the start-accepting edge.
REQ-024 busy SHALL equal 1 in SCAN and DONE and 0 in IDLE.
REQ-025 start SHALL be ignored in SCAN and DONE.
REQ-026 abort=1 in SCAN SHALL return the FSM to IDLE at the next edge, with no done pulse.
REQ-027 After an abort, table_out and ones SHALL keep their partial values, and match SHALL be 0.
REQ-028 abort in IDLE or DONE SHALL have no effect; if abort and start are both 1 in IDLE, start SHALL win.
REQ-029 table_out, ones, match and diff_idx SHALL hold their values in IDLE until the next accepted start.
REQ-030 ones SHALL never overflow, since its width of NVARS+1 bits covers the maximum count of 2**NVARS.
REQ-031 diff_idx SHALL be computed combinationally with a priority encoder on table_out XOR effective reference, and registered on entry to DONE.

Reset
REQ-032 On rst_n=0 the block SHALL enter IDLE at once.
REQ-033 During reset, vars, table_out, ones, diff_idx, busy, done and match SHALL all be 0.
REQ-034 Reset mid-scan SHALL discard the scan completely; no done pulse SHALL follow reset release.

Structure
REQ-035 A shared package tt_pkg SHALL hold the state encoding (IDLE=2'd0, SCAN=2'd1, DONE=2'd2) and the NVARS and SETTLE range limits.
REQ-036 A sub-module tt_first_diff SHALL implement the parametrised lowest-set-bit priority encoder.
REQ-037 The function under test SHALL be external; the bench SHALL wire vars to f_in through a combinational model.

Verification (NVARS=3, vars={x,y,z})
REQ-038 SETTLE=1, f = x XNOR y, mode=0, ref=8'b1100_0011, start pulse -> done after exactly 9 cycles; table_out=8'hC3, ones=4, match=1.
REQ-039 Same f, mode=1, ref=8'b0011_1100 (maxterms) -> match=1, table_out=8'hC3.
REQ-040 f = x&y&z, ref=8'h81 -> table_out=8'h80, ones=1, match=0, diff_idx=0.
REQ-041 SETTLE=3, f=1 -> done after exactly 25 cycles; vars changes every 3 cycles; ones=8.
REQ-042 abort asserted at vars=4 -> busy low next cycle, no done, table_out[3:0] captured, match=0; a start asserted while busy is ignored.
REQ-043 rst_n low mid-scan, then high -> all outputs 0, FSM in IDLE, no done pulse; a new start then completes normally.
